// File: rtl/usb_byte_responder_pkg.sv
// Shared constants for the USB register-access responder: FSM encodings,
// command bytes and default response bytes.
package usb_responder_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GET_ADDR = 2'd1;
  localparam logic [1:0] ST_GET_DATA = 2'd2;
  localparam logic [1:0] ST_RESPOND  = 2'd3;

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;

  localparam logic [7:0] DEFAULT_ACK = 8'h06;
  localparam logic [7:0] DEFAULT_NAK = 8'h15;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/usb_byte_responder_regfile.sv
// NUM_REGS x 8 register file: one write port, one combinational read port,
// and the whole array exposed flattened for board-level outputs.
module usb_resp_regfile #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [ADDR_W-1:0]       i_waddr,
  input  logic [7:0]              i_wdata,
  input  logic [ADDR_W-1:0]       i_raddr,
  output logic [7:0]              o_rdata,
  output logic [NUM_REGS*8-1:0]   o_regs
);

  logic [7:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range reads only occur for NAKed addresses, so the value is unused.
  assign o_rdata = (int'(i_raddr) < NUM_REGS) ? r_mem[i_raddr] : 8'h00;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs[g*8 +: 8] = r_mem[g];
  end

endmodule

// File: rtl/usb_byte_responder.sv
// Byte-stream register-access responder: decodes 'W' addr data / 'R' addr
// commands from the host and returns one response byte per command.
module usb_byte_responder
  import usb_responder_pkg::*;
#(
  parameter int         NUM_REGS       = 16,
  parameter int         ADDR_W         = 4,
  parameter int         TIMEOUT_CYCLES = 4800000,
  parameter logic [7:0] ACK_BYTE       = DEFAULT_ACK,
  parameter logic [7:0] NAK_BYTE       = DEFAULT_NAK
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            err_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [1:0]        r_state;
  logic              r_rx_ready;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_err;
  logic [TMO_W-1:0]  r_tmo;

  logic [1:0]        w_state_nxt;
  logic              w_rx_acc;
  logic              w_tx_acc;
  logic              w_addr_bad;
  logic              w_tmo_exp;
  logic              w_tmo_hit;
  logic              w_nak;
  logic              w_we;
  logic              w_tx_load;
  logic [7:0]        w_tx_nxt;
  logic [7:0]        w_rd_data;

  assign w_rx_acc   = rx_valid && r_rx_ready;
  assign w_tx_acc   = r_tx_valid && tx_ready;
  assign w_addr_bad = (int'(rx_data) >= NUM_REGS);
  assign w_tmo_exp  = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  usb_resp_regfile #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regfile (
    .i_clk   (clk_48mhz),
    .i_rst   (reset),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (rx_data),
    .i_raddr (rx_data[ADDR_W-1:0]),
    .o_rdata (w_rd_data),
    .o_regs  (regs_out)
  );

  // An accepted byte always takes priority over an expiring timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_load   = 1'b0;
    w_tx_nxt    = 8'h00;
    w_nak       = 1'b0;
    w_we        = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_acc) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            w_state_nxt = ST_GET_ADDR;
          end else begin
            w_state_nxt = ST_RESPOND;
            w_tx_load   = 1'b1;
            w_tx_nxt    = NAK_BYTE;
            w_nak       = 1'b1;
          end
        end
      end
      ST_GET_ADDR: begin
        if (w_rx_acc) begin
          if (w_addr_bad) begin
            w_state_nxt = ST_RESPOND;
            w_tx_load   = 1'b1;
            w_tx_nxt    = NAK_BYTE;
            w_nak       = 1'b1;
          end else if (!r_op_wr) begin
            w_state_nxt = ST_RESPOND;
            w_tx_load   = 1'b1;
            w_tx_nxt    = w_rd_data;
          end else begin
            w_state_nxt = ST_GET_DATA;
          end
        end else if (w_tmo_exp) begin
          w_state_nxt = ST_IDLE;
          w_tmo_hit   = 1'b1;
        end
      end
      ST_GET_DATA: begin
        if (w_rx_acc) begin
          w_we        = 1'b1;
          w_state_nxt = ST_RESPOND;
          w_tx_load   = 1'b1;
          w_tx_nxt    = ACK_BYTE;
        end else if (w_tmo_exp) begin
          w_state_nxt = ST_IDLE;
          w_tmo_hit   = 1'b1;
        end
      end
      default: begin
        if (w_tx_acc) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rx_ready  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_op_wr     <= 1'b0;
      r_addr      <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_err       <= 8'h00;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rx_ready  <= (w_state_nxt != ST_RESPOND);
      r_wr_strobe <= w_we;
      if (w_we) r_wr_addr <= r_addr;
      if (r_state == ST_IDLE && w_rx_acc) r_op_wr <= (rx_data == CMD_WRITE);
      if (r_state == ST_GET_ADDR && w_rx_acc) r_addr <= rx_data[ADDR_W-1:0];
      if (w_tx_load) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_tx_nxt;
      end else if (w_tx_acc) begin
        r_tx_valid <= 1'b0;
      end
      if (w_nak || w_tmo_hit) r_err <= sat_inc8(r_err);
      // Clearing on entry to IDLE also resets the count at expiry, so it never wraps.
      if (w_rx_acc || w_state_nxt == ST_IDLE) begin
        r_tmo <= '0;
      end else if (r_state == ST_GET_ADDR || r_state == ST_GET_DATA) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
    end
  end

  assign rx_ready  = r_rx_ready;
  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign err_count = r_err;

endmodule
